xgriscv_mdu: RTL and testbench

Multi-cycle RV32M multiply/divide unit with its own sequencing FSM, in the EX stage of the xgriscv pipeline beside the ALU. The decode-stage controller flags M-extension ops. This block accepts one op at a time, stalls the pipeline while it computes, and returns a result with a one-cycle done pulse. Multiply takes a fixed 2 cycles. Divide uses a 32-step iterative restoring divider.

---
 rtl/xgriscv_mdu_pkg.sv | 47 ++++
 rtl/xgriscv_mdu_div.sv | 68 ++++++
 rtl/xgriscv_mdu.sv | 156 +++++++++++++++
 tb/tb_xgriscv_mdu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/xgriscv_mdu_pkg.sv
// Shared constants for the xgriscv M-extension unit: funct7/funct3 encodings,
// MDU state encodings and small funct3 decode helpers.
package xgriscv_mdu_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    localparam logic [1:0] MDU_IDLE = 2'd0;
    localparam logic [1:0] MDU_MUL  = 2'd1;
    localparam logic [1:0] MDU_DIV  = 2'd2;
    localparam logic [1:0] MDU_DONE = 2'd3;

    function automatic logic is_muldiv(input logic [6:0] funct7);
        return funct7 == FUNCT7_MULDIV;
    endfunction

    function automatic logic f3_is_div(input logic [2:0] f3);
        return (f3 == FUNCT3_DIV) || (f3 == FUNCT3_DIVU) ||
               (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
    endfunction

    function automatic logic f3_div_signed(input logic [2:0] f3);
        return (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

    // rs1 is sign-extended for every multiply except MULHU
    function automatic logic f3_mul_a_signed(input logic [2:0] f3);
        return (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU);
    endfunction

    function automatic logic f3_mul_b_signed(input logic [2:0] f3);
        return f3 == FUNCT3_MULH;
    endfunction

endpackage

// File: rtl/xgriscv_mdu_div.sv
// Iterative restoring divider core for the xgriscv MDU: unsigned magnitudes,
// one quotient bit per cycle over 32 cycles. Built only when
// XGRISCV_MDU_DIV_EN is defined.
`ifdef XGRISCV_MDU_DIV_EN
module xgriscv_mdu_div
    import xgriscv_mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        div_last_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic        busy_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q, quot_q, dvs_q;
    logic [32:0] shifted, diff;
    logic        step_ok;
    logic [31:0] rem_step, quot_step;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted   = {rem_q, quot_q[31]};
        diff      = shifted - {1'b0, dvs_q};
        step_ok   = ~diff[32];
        rem_step  = step_ok ? diff[31:0] : shifted[31:0];
        quot_step = {quot_q[30:0], step_ok};
    end

    // Step outputs are the post-step values so the parent can register the
    // final result in the same cycle as the last step
    assign div_last_o = busy_q && (cnt_q == 6'd31);
    assign quot_o     = quot_step;
    assign rem_o      = rem_step;

    // Step counter and partial remainder/quotient registers
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            busy_q <= 1'b0;
            cnt_q  <= 6'd0;
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= 6'd0;
            rem_q  <= '0;
            quot_q <= dividend_i;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            rem_q  <= rem_step;
            quot_q <= quot_step;
            if (cnt_q == 6'd31) begin
                busy_q <= 1'b0;
                cnt_q  <= 6'd0;
            end else begin
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/xgriscv_mdu.sv
// xgriscv RV32M multiply/divide unit (EX stage). Multiply takes 2 cycles,
// divide 33 via the iterative divider. Define XGRISCV_MDU_DIV_EN for the
// divider; without it divide ops complete in 1 cycle with result 0.
module xgriscv_mdu
    import xgriscv_mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [1:0]  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] result_q, result_d;
    logic [63:0] mul_a, mul_b, mul_prod;

`ifdef XGRISCV_MDU_DIV_EN
    logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic        div_start, div_last, div_sgn;
    logic [31:0] div_quot, div_rem, a_mag, b_mag;

    // Divider works on magnitudes; signs are reapplied on the last step
    assign div_sgn = f3_div_signed(funct3);
    assign a_mag   = (div_sgn && a[31]) ? -a : a;
    assign b_mag   = (div_sgn && b[31]) ? -b : b;

    xgriscv_mdu_div u_div (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .flush_i    (flush),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .div_last_o (div_last),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // Result sign flags captured at accept
    always_ff @(posedge clk) begin
        if (reset) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end
`endif

    // 64-bit product of sign/zero-extended latched operands
    always_comb begin
        mul_a    = {{32{f3_mul_a_signed(funct3_q) & a_q[31]}}, a_q};
        mul_b    = {{32{f3_mul_b_signed(funct3_q) & b_q[31]}}, b_q};
        mul_prod = mul_a * mul_b;
    end

    // Sequencing FSM: accept, compute, one-cycle done, back to idle
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
`ifdef XGRISCV_MDU_DIV_EN
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        div_start = 1'b0;
`endif
        case (state_q)
            MDU_IDLE: begin
                if (valid && !flush) begin
                    funct3_d = funct3;
                    a_d      = a;
                    b_d      = b;
                    if (!f3_is_div(funct3)) begin
                        state_d = MDU_MUL;
                    end else begin
                        state_d = MDU_DONE;
`ifdef XGRISCV_MDU_DIV_EN
                        if (b == '0) begin
                            result_d = f3_is_rem(funct3) ? a : '1;
                        end else if (div_sgn && a == 32'h8000_0000 && b == '1) begin
                            result_d = f3_is_rem(funct3) ? '0 : 32'h8000_0000;
                        end else begin
                            state_d   = MDU_DIV;
                            div_start = 1'b1;
                            q_neg_d   = div_sgn & (a[31] ^ b[31]);
                            r_neg_d   = div_sgn & a[31];
                        end
`else
                        result_d = '0;
`endif
                    end
                end
            end
            MDU_MUL: begin
                result_d = (funct3_q == FUNCT3_MUL) ? mul_prod[31:0] : mul_prod[63:32];
                state_d  = MDU_DONE;
            end
            MDU_DIV: begin
`ifdef XGRISCV_MDU_DIV_EN
                if (div_last) begin
                    if (f3_is_rem(funct3_q)) begin
                        result_d = r_neg_q ? -div_rem : div_rem;
                    end else begin
                        result_d = q_neg_q ? -div_quot : div_quot;
                    end
                    state_d = MDU_DONE;
                end
`else
                state_d = MDU_IDLE;
`endif
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        // A killed op never updates the result
        if (flush) begin
            state_d  = MDU_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MDU_IDLE;
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign done   = (state_q == MDU_DONE);
    assign stall  = valid & ~done;
    assign result = result_q;

endmodule

// File: tb/tb_xgriscv_mdu.sv
// Directed self-checking bench for xgriscv_mdu. Divide-specific vectors are
// selected by XGRISCV_MDU_DIV_EN to match the build of the design.
module tb_xgriscv_mdu;

    logic        clk = 1'b0;
    logic        reset, valid, flush;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        stall, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xgriscv_mdu #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op at the current cycle (cycle 0), wait for done within a
    // bounded window, check latency, result, stall and the one-cycle pulse.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_res);
        bit seen;
        int lat;
        seen   = 1'b0;
        lat    = -1;
        funct3 = f3;
        a      = av;
        b      = bv;
        valid  = 1'b1;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                if (c < 2 && c < exp_lat) check({tag, " stall"}, {31'b0, stall}, 32'd1);
                @(posedge clk);
                #1;
            end
        end
        check({tag, " done seen"}, {31'b0, seen}, 32'd1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " stall at done"}, {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        check({tag, " done pulse"}, {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        valid  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset result", result, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;

        // Multiply: -1 * 2
        run_op("MUL", 3'b000, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFE);
        run_op("MULH", 3'b001, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF);
        run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'd2, 2, 32'h0000_0001);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);

        // Flush in the accept cycle: op must not be taken
        funct3 = 3'b000;
        a      = 32'd3;
        b      = 32'd4;
        valid  = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush-accept no done", {31'b0, done}, 32'd0);
        end
        check("flush-accept result kept", result, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;

`ifdef XGRISCV_MDU_DIV_EN
        run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 33, 32'd14);
        run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 33, 32'd2);
        run_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run_op("REM 5/0", 3'b110, 32'd5, 32'd0, 1, 32'd5);
        run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);

        // Flush at cycle 10 of a divide, then a multiply at cycle 11
        funct3 = 3'b100;
        a      = 32'd100;
        b      = 32'd7;
        valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("flush-div no early done", {31'b0, done}, 32'd0);
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush-div done at flush", {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush-div result kept", result, 32'h8000_0000);
        check("flush-div no done after", {31'b0, done}, 32'd0);
        run_op("MUL after flush", 3'b000, 32'd3, 32'd4, 2, 32'd12);
`else
        run_op("DIV off", 3'b100, 32'd10, 32'd3, 1, 32'd0);
        run_op("REMU off", 3'b111, 32'd5, 32'd0, 1, 32'd0);
        run_op("MUL 3x4", 3'b000, 32'd3, 32'd4, 2, 32'd12);
`endif

        // Reset at cycle 1 of a multiply
        funct3 = 3'b000;
        a      = 32'd5;
        b      = 32'd6;
        valid  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        check("reset-mul no done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset-mul done low", {31'b0, done}, 32'd0);
            check("reset-mul result", result, 32'd0);
        end
        @(posedge clk);
        #1;
        run_op("MUL 7x6", 3'b000, 32'd7, 32'd6, 2, 32'd42);
        run_op("MULH neg", 3'b001, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

endmodule
